// File: rtl/clk_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : clk_fsm_pkg                                              |
// | Brief     : Shared types and constants for the FSM clock chain       |
// |             (seconds, minutes and hours stages).                     |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package clk_fsm_pkg;

  // Width of every time-of-day field in the chain
  localparam int TIME_W = 6;

  // Terminal count shared by the seconds and minutes stages
  localparam int SEC_MAX_C = 59;

  // Control state, 3-bit encoding; unused codes recover through S_RESET
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3
  } state_t;

endpackage : clk_fsm_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tick_prescaler                                           |
// | Brief     : Divides clk down to a single-cycle tick every CLK_DIV    |
// |             running cycles; freezes when run is low.                 |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tick_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;

  // Divider counter: clear wins, otherwise count while running and wrap at the last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (clr) begin
      r_div_cnt <= '0;
    end else if (run) begin
      if (r_div_cnt == c_div_last) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Tick only counts while running, so a frozen counter parked on the last value stays quiet
  always_comb begin
    tick = run && (r_div_cnt == c_div_last);
  end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/fsm_second.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fsm_second                                               |
// | Brief     : Seconds stage of the FSM clock chain. Counts 0..SEC_MAX  |
// |             on prescaled ticks, supports preload, and pulses         |
// |             min_tick on each wrap to 0.                              |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module fsm_second
  import clk_fsm_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int SEC_MAX = SEC_MAX_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TIME_W-1:0] sec_in,
  input  logic              sec_in_load,
  input  logic              en,
  output logic [TIME_W-1:0] sec_count,
  output logic              min_tick,
  output logic              running
);

  localparam logic [TIME_W-1:0] c_sec_max = TIME_W'(SEC_MAX);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_tick;
  logic              w_run;
  logic              w_load;
  logic              w_advance;
  logic [TIME_W-1:0] w_load_val;
  logic [TIME_W-1:0] r_sec_count;
  logic              r_min_tick;

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .clr   (w_load),
    .tick  (w_tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a load in RUN/HOLD keeps the current state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (sec_in_load) begin
          w_state_nxt = en ? S_RUN : S_HOLD;
        end
      end
      S_RUN: begin
        if (!sec_in_load && !en) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!sec_in_load && en) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  // Output/control decode: load beats tick, out-of-range preloads clamp to 0
  always_comb begin
    w_run      = (r_state == S_RUN);
    w_load     = sec_in_load &&
                 ((r_state == S_WAIT) || (r_state == S_RUN) || (r_state == S_HOLD));
    w_advance  = w_run && w_tick && !w_load;
    w_load_val = (sec_in > c_sec_max) ? '0 : sec_in;
    running    = w_run;
  end

  // Seconds and min_tick registers; min_tick marks the SEC_MAX -> 0 wrap only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_count <= '0;
      r_min_tick  <= 1'b0;
    end else begin
      r_min_tick <= w_advance && (r_sec_count == c_sec_max);
      if (w_load) begin
        r_sec_count <= w_load_val;
      end else if (w_advance) begin
        r_sec_count <= (r_sec_count == c_sec_max) ? '0 : r_sec_count + TIME_W'(1);
      end
    end
  end

  assign sec_count = r_sec_count;
  assign min_tick  = r_min_tick;

endmodule : fsm_second
`default_nettype wire

// File: tb/tb_fsm_second.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_fsm_second                                            |
// | Brief     : Directed self-checking bench for fsm_second, CLK_DIV=4.  |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_fsm_second;

  localparam int CLK_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] sec_in;
  logic       sec_in_load;
  logic       en;
  logic [5:0] sec_count;
  logic       min_tick;
  logic       running;

  int checks;
  int failures;

  fsm_second #(
    .CLK_DIV (CLK_DIV),
    .SEC_MAX (59)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sec_in      (sec_in),
    .sec_in_load (sec_in_load),
    .en          (en),
    .sec_count   (sec_count),
    .min_tick    (min_tick),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int state_code();
    logic [2:0] s;
    s = dut.r_state;
    return int'(s);
  endfunction

  // Advance one rising edge and settle 1 ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle load pulse
  task automatic load(input int v, input logic e);
    sec_in      = 6'(v);
    sec_in_load = 1'b1;
    en          = e;
    step();
    sec_in_load = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    sec_in      = '0;
    sec_in_load = 1'b0;
    en          = 1'b0;

    // 1. reset then idle without load
    #3;
    check("rst_async_sec", int'(sec_count), 0);
    repeat (3) step();
    check("rst_sec", int'(sec_count), 0);
    check("rst_min_tick", int'(min_tick), 0);
    check("rst_running", int'(running), 0);
    check("rst_state", state_code(), 0);
    rst_n = 1'b1;
    step();
    check("idle_state_wait", state_code(), 1);
    for (int i = 0; i < 19; i++) begin
      en = 1'b1;
      step();
      check("idle_sec", int'(sec_count), 0);
      check("idle_running", int'(running), 0);
      check("idle_min_tick", int'(min_tick), 0);
    end
    check("idle_state_end", state_code(), 1);

    // 2. load 10 and run
    load(10, 1'b1);
    check("ld10_sec", int'(sec_count), 10);
    check("ld10_running", int'(running), 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("run10_sec", int'(sec_count), 10 + k / 4);
    end

    // 3. wrap 58 -> 59 -> 0 -> 1 with single min_tick
    load(58, 1'b1);
    check("ld58_sec", int'(sec_count), 58);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("wrap_sec", int'(sec_count), (k < 4) ? 58 : (k < 8) ? 59 : (k < 12) ? 0 : 1);
      check("wrap_min_tick", int'(min_tick), (k == 8) ? 1 : 0);
    end

    // 4. hold preserves the partial divider count
    load(20, 1'b1);
    step();
    step();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold_sec", int'(sec_count), 20);
      check("hold_running", int'(running), 0);
    end
    en = 1'b1;
    step();
    check("resume_sec_a", int'(sec_count), 20);
    check("resume_running", int'(running), 1);
    step();
    check("resume_sec_b", int'(sec_count), 21);

    // 5. load beats a tick at 59, and out-of-range loads clamp to 0
    load(59, 1'b1);
    step();
    step();
    step();
    load(33, 1'b1);
    check("ldtick_sec", int'(sec_count), 33);
    check("ldtick_min_tick", int'(min_tick), 0);
    load(60, 1'b1);
    check("clamp60_sec", int'(sec_count), 0);
    load(63, 1'b1);
    check("clamp63_sec", int'(sec_count), 0);
    load(45, 1'b1);
    check("ld45_sec", int'(sec_count), 45);

    // 6. asynchronous reset mid-count
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sec", int'(sec_count), 0);
    check("arst_running", int'(running), 0);
    check("arst_min_tick", int'(min_tick), 0);
    check("arst_state", state_code(), 0);
    step();
    rst_n = 1'b1;
    check("arst_rel_state", state_code(), 0);
    step();
    check("arst_wait_state", state_code(), 1);
    repeat (6) step();
    check("arst_no_count", int'(sec_count), 0);
    check("arst_still_wait", state_code(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fsm_second
`default_nettype wire
